// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI port constants, timing helpers and sequencer state type.
package midi_pkg;
    localparam logic [7:0] STAT_LO   = 8'h80;
    localparam logic [7:0] STAT_HI   = 8'hEF;
    localparam logic [7:0] SYSCOM_HI = 8'hF7;
    localparam logic [7:0] RT_CLOCK  = 8'hF8;
    localparam logic [7:0] RT_SENSE  = 8'hFE;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_POP, SEQ_LOAD, SEQ_SEND} seq_state_t;

    function automatic int clks_per_bit(input int clock, input int baud);
        return clock / baud;
    endfunction

    function automatic int act_cycles(input int clock, input int ms);
        return clock / 1000 * ms;
    endfunction

    function automatic logic is_rt(input logic [7:0] b);
        return b == RT_CLOCK || b == RT_SENSE;
    endfunction
endpackage

// File: rtl/fifo.sv
// fifo: synchronous FIFO with registered read data (valid the cycle after rd_en).
module fifo #(
    parameter int W  = 8,
    parameter int AW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_rd, do_wr;
    assign full  = cnt == (AW+1)'(2**AW);
    assign empty = cnt == '0;
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= wr_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) wp <= wp + AW'(1);
            if (do_rd) begin
                rp      <= rp + AW'(1);
                rd_data <= mem[rp];
            end
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
endmodule

// File: rtl/midi_tx_seq.sv
// midi_tx_seq: FIFO-to-UART sequencer; MIDI_RUNNING_STATUS_EN adds running-status
// compression that drops a repeated channel status byte.
module midi_tx_seq
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       empty,
    input  logic [7:0] rd_data,
    input  logic       busy,
    input  logic       done,
    output logic       rd_en,
    output logic       start,
    output logic [7:0] tx_byte
);
    seq_state_t state, next;
    logic drop;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic is_stat;
    assign is_stat = rd_data >= STAT_LO && rd_data <= STAT_HI;
    assign drop    = is_stat && rd_data == last_status;
    // system common clears running status; real-time leaves it alone
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_status <= 8'h00;
        else if (state == SEQ_LOAD)
            last_status <= is_stat ? rd_data :
                           (rd_data > STAT_HI && rd_data <= SYSCOM_HI) ? 8'h00 : last_status;
`else
    assign drop = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SEQ_IDLE;
        else state <= next;
    always_comb
        next = state == SEQ_IDLE ? ((!empty && !busy) ? SEQ_POP : SEQ_IDLE) :
               state == SEQ_POP  ? SEQ_LOAD :
               state == SEQ_LOAD ? (drop ? SEQ_IDLE : SEQ_SEND) :
               (done ? SEQ_IDLE : SEQ_SEND);
    always_comb begin
        rd_en   = state == SEQ_POP;
        start   = state == SEQ_LOAD && !drop;
        tx_byte = rd_data;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with input synchroniser, start-bit glitch rejection and framing check.
module uart_rx #(
    parameter int CLKS_PER_BIT = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial,
    output logic       valid,
    output logic       err,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [1:0] sync;
    logic prev, busy, rx, tick;
    logic [3:0] bit_n;
    logic [CW-1:0] cnt;
    logic [7:0] sh;
    assign rx   = sync[1];
    // bit_n 0 is the start bit, re-checked at its midpoint; later bits are a full period apart
    assign tick = cnt == (bit_n == 4'd0 ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync  <= 2'b11;
            prev  <= 1'b1;
            busy  <= 1'b0;
            bit_n <= '0;
            cnt   <= '0;
            sh    <= '0;
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            sync  <= {sync[0], serial};
            prev  <= rx;
            valid <= 1'b0;
            err   <= 1'b0;
            if (!busy) begin
                busy  <= prev && !rx;
                bit_n <= '0;
                cnt   <= '0;
            end else if (!tick) cnt <= cnt + CW'(1);
            else begin
                cnt   <= '0;
                bit_n <= bit_n + 4'd1;
                if (bit_n == 4'd0) busy <= !rx;
                else if (bit_n == 4'd9) begin
                    busy  <= 1'b0;
                    valid <= rx;
                    err   <= !rx;
                    if (rx) data <= sh;
                end else sh <= {rx, sh[7:1]};
            end
        end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter; serial is the LSB of a shift register that resets to all ones.
module uart_tx #(
    parameter int CLKS_PER_BIT = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       serial,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [9:0] sh;
    logic [3:0] bit_n;
    logic [CW-1:0] cnt;
    assign serial = sh[0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh    <= '1;
            bit_n <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    sh    <= {1'b1, data, 1'b0};
                    bit_n <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                cnt   <= '0;
                sh    <= {1'b1, sh[9:1]};
                bit_n <= bit_n + 4'd1;
                if (bit_n == 4'd9) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/midi_port_gen2.sv
// midi_port_gen2: MIDI DIN port with UART RX, buffered TX sequencer and activity LEDs.
// Build option MIDI_RUNNING_STATUS_EN enables TX running-status compression.
module midi_port_gen2
    import midi_pkg::*;
#(
    parameter int CLOCK      = 12_000_000,
    parameter int BAUD       = 31_250,
    parameter int TX_DEPTH_W = 8,
    parameter int ACT_MS     = 50,
    parameter int FILTER_RT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_overflow,
    output logic       tx_serial,
    input  logic       rx_serial,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    output logic       activity_in,
    output logic       activity_out
);
    localparam int CPB = clks_per_bit(CLOCK, BAUD);
    localparam int ACT = act_cycles(CLOCK, ACT_MS);
    localparam int AW  = $clog2(ACT + 1) > 21 ? $clog2(ACT + 1) : 21;
    logic [1:0] rst_sync;
    logic rst_i_n, wr_en, rd_en, full, empty, start, busy, done, in_evt, out_evt;
    logic [7:0] rd_data, tx_byte;
    logic [AW-1:0] act_in_cnt, act_out_cnt;
    assign rst_i_n      = rst_sync[1];
    assign tx_ready     = !full;
    assign wr_en        = tx_valid && tx_ready;
    assign in_evt       = rx_valid && !(FILTER_RT != 0 && is_rt(rx_data));
    assign out_evt      = wr_en && !(FILTER_RT != 0 && is_rt(tx_data));
    assign activity_in  = act_in_cnt != '0;
    assign activity_out = act_out_cnt != '0;
    // assert asynchronously, release two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else rst_sync <= {rst_sync[0], 1'b1};
    always_ff @(posedge clk or negedge rst_i_n)
        if (!rst_i_n) begin
            tx_overflow <= 1'b0;
            act_in_cnt  <= '0;
            act_out_cnt <= '0;
        end else begin
            tx_overflow <= tx_overflow || (tx_valid && !tx_ready);
            act_in_cnt  <= in_evt ? AW'(ACT) : act_in_cnt - AW'(activity_in);
            act_out_cnt <= out_evt ? AW'(ACT) : act_out_cnt - AW'(activity_out);
        end
    fifo #(.W(8), .AW(TX_DEPTH_W)) u_fifo (
        .clk(clk), .rst_n(rst_i_n), .wr_en(wr_en), .wr_data(tx_data),
        .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty)
    );
    midi_tx_seq u_seq (
        .clk(clk), .rst_n(rst_i_n), .empty(empty), .rd_data(rd_data), .busy(busy),
        .done(done), .rd_en(rd_en), .start(start), .tx_byte(tx_byte)
    );
    uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
        .clk(clk), .rst_n(rst_i_n), .start(start), .data(tx_byte),
        .serial(tx_serial), .busy(busy), .done(done)
    );
    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk(clk), .rst_n(rst_i_n), .serial(rx_serial),
        .valid(rx_valid), .err(rx_err), .data(rx_data)
    );
endmodule

// File: tb/tb_midi_port_gen2.sv
// tb_midi_port_gen2: randomized bench for midi_port_gen2 against a byte-level reference model.
module tb_midi_port_gen2;
    localparam int CLOCK = 160_000;
    localparam int BAUD  = 10_000;
    localparam int CPB   = CLOCK / BAUD;
    localparam int DW    = 3;
    localparam int DEPTH = 1 << DW;
    localparam int ACT   = CLOCK / 1000 * 1;

    logic clk, rst_n, tx_valid, tx_ready, tx_overflow, tx_serial, rx_serial;
    logic rx_valid, rx_err, activity_in, activity_out;
    logic [7:0] tx_data, rx_data;

    int n_chk = 0, n_err = 0, ain_n = 0, aout_n = 0, rx_errs = 0;
    logic [7:0] rx_q[$], tx_q[$], exp_q[$];
    time starts[$];
    time t_wr;
    logic [7:0] last_good = 8'h00;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] m_last = 8'h00;
`endif
    logic [7:0] seq5 [9] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3E, 8'h64, 8'hF8, 8'h90, 8'h40};

    midi_port_gen2 #(.CLOCK(CLOCK), .BAUD(BAUD), .TX_DEPTH_W(DW), .ACT_MS(1), .FILTER_RT(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_overflow(tx_overflow), .tx_serial(tx_serial), .rx_serial(rx_serial),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
        .activity_in(activity_in), .activity_out(activity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: the byte sequence the line should carry for each accepted write
    function automatic void model_wr(input logic [7:0] b);
`ifdef MIDI_RUNNING_STATUS_EN
        if (b >= 8'h80 && b <= 8'hEF) begin
            if (b == m_last) return;
            m_last = b;
        end else if (b >= 8'hF0 && b <= 8'hF7) m_last = 8'h00;
`endif
        exp_q.push_back(b);
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        cyc_wait(n * (10 * CPB + 8) + 20);
    endtask

    task automatic wr(input logic [7:0] b, input logic acc);
        tx_valid = 1'b1;
        tx_data  = b;
        if (acc) model_wr(b);
        @(posedge clk);
        t_wr = $time;
        #1 tx_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_serial = f[i];
            cyc_wait(CPB);
        end
        rx_serial = 1'b1;
    endtask

    task automatic cmp_tx(input string tag);
        chk({tag, "_count"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) chk(tag, tx_q[i], exp_q[i]);
        tx_q.delete();
        exp_q.delete();
        starts.delete();
    endtask

    task automatic wait_line_low(input string tag);
        for (int i = 0; i < 40 && tx_serial; i++) cyc_wait(1);
        chk(tag, tx_serial, 1'b0);
    endtask

    always @(negedge clk) begin
        if (activity_in) ain_n++;
        if (activity_out) aout_n++;
        if (rx_valid) rx_q.push_back(rx_data);
        if (rx_err) rx_errs++;
    end

    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge tx_serial);
            starts.push_back($time);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 b[i] = tx_serial;
            end
            repeat (CPB) @(posedge clk);
            #1 chk("tx_stop", tx_serial, 1'b1);
            tx_q.push_back(b);
        end
    end

    initial begin
        #900_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        int e0;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_serial = 1'b1;
        cyc_wait(3);
        chk("rst_tx_serial", tx_serial, 1'b1);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_overflow", tx_overflow, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_flags", {rx_valid, rx_err}, 2'b00);
        chk("rst_activity", {activity_in, activity_out}, 2'b00);
        rst_n = 1'b1;
        cyc_wait(4);

        ain_n = 0;
        send_rx(8'h90, 1'b1);
        cyc_wait(2);
        chk("rx90_count", rx_q.size(), 1);
        if (rx_q.size() != 0) chk("rx90_data", rx_q[0], 8'h90);
        chk("rx90_hold", rx_data, 8'h90);
        chk("rx90_act_on", activity_in, 1'b1);
        rx_q.delete();
        last_good = 8'h90;
        cyc_wait(ACT + 10);
        chk("rx90_act_len", ain_n, ACT);
        chk("rx90_act_off", activity_in, 1'b0);

        e0 = rx_errs;
        send_rx(8'h45, 1'b0);
        cyc_wait(CPB);
        chk("ferr_pulse", rx_errs, e0 + 1);
        chk("ferr_no_valid", rx_q.size(), 0);
        chk("ferr_hold", rx_data, 8'h90);
        rx_serial = 1'b0;
        cyc_wait(CPB / 2);
        rx_serial = 1'b1;
        cyc_wait(12 * CPB);
        chk("glitch_no_valid", rx_q.size(), 0);
        chk("glitch_no_err", rx_errs, e0 + 1);

        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            logic ok;
            b  = 8'($urandom_range(0, 255));
            ok = $urandom_range(0, 3) != 0;
            e0 = rx_errs;
            send_rx(b, ok);
            cyc_wait(CPB);
            if (ok) begin
                last_good = b;
                chk("rnd_rx_count", rx_q.size(), 1);
                if (rx_q.size() != 0) chk("rnd_rx_data", rx_q[0], b);
            end else begin
                chk("rnd_rx_err", rx_errs, e0 + 1);
                chk("rnd_rx_hold", rx_data, last_good);
                chk("rnd_rx_none", rx_q.size(), 0);
            end
            rx_q.delete();
        end

        aout_n = 0;
        starts.delete();
        wr(8'h90, 1'b1);
        wr(8'h3C, 1'b1);
        wr(8'h64, 1'b1);
        drain(4);
        chk("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("latency_le4", (starts[0] - (t_wr - 20)) / 10 <= 4, 1'b1);
            chk("gap1_le4", (starts[1] - starts[0]) / 10 - 10 * CPB <= 4, 1'b1);
            chk("gap2_le4", (starts[2] - starts[1]) / 10 - 10 * CPB <= 4, 1'b1);
        end
        chk("b2b_act_len", aout_n, ACT + 2);
        cmp_tx("b2b_tx");

        for (int k = 0; k < 5; k++) begin
            int n, r;
            logic [7:0] b;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 3);
                b = r == 0 ? 8'h90 : r == 1 ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom_range(0, 255));
                wr(b, 1'b1);
                cyc_wait($urandom_range(0, 3));
            end
            drain(n + 1);
            cmp_tx("rnd_tx");
        end

        wr(8'h55, 1'b1);
        wait_line_low("ovf_line_busy");
        for (int i = 0; i <= DEPTH; i++) begin
            chk("ovf_ready", tx_ready, i < DEPTH);
            wr(8'($urandom_range(0, 127)), i < DEPTH);
        end
        chk("ovf_flag", tx_overflow, 1'b1);
        drain(DEPTH + 2);
        chk("ovf_emitted", tx_q.size(), DEPTH + 1);
        cmp_tx("ovf_tx");
        chk("ovf_sticky", tx_overflow, 1'b1);

        wr(8'h00, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wait_line_low("mid_start");
        cyc_wait(3 * CPB);
        chk("mid_line_low", tx_serial, 1'b0);
        chk("mid_act_out", activity_out, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_line_high", tx_serial, 1'b1);
        chk("abort_act_out", activity_out, 1'b0);
        chk("abort_act_in", activity_in, 1'b0);
        chk("abort_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
        m_last = 8'h00;
`endif
        cyc_wait(11 * CPB);
        tx_q.delete();
        starts.delete();
        cyc_wait(20 * CPB);
        chk("post_rst_quiet", tx_q.size(), 0);
        chk("post_rst_ovf", tx_overflow, 1'b0);

        for (int i = 0; i < 9; i++) wr(seq5[i], 1'b1);
        drain(10);
`ifdef MIDI_RUNNING_STATUS_EN
        chk("rs_count", tx_q.size(), 7);
`else
        chk("rs_count", tx_q.size(), 9);
`endif
        cmp_tx("rs_seq");
        wr(8'hF0, 1'b1);
        wr(8'h90, 1'b1);
        drain(3);
        if (tx_q.size() == 2) chk("rs_resend", tx_q[1], 8'h90);
        cmp_tx("rs_f0");

        cyc_wait(ACT + 10);
        ain_n = 0;
        aout_n = 0;
        rx_q.delete();
        send_rx(8'hF8, 1'b1);
        send_rx(8'hF8, 1'b1);
        send_rx(8'hFE, 1'b1);
        wr(8'hF8, 1'b1);
        wr(8'hFE, 1'b1);
        drain(3);
        chk("rt_rx_count", rx_q.size(), 3);
        if (rx_q.size() != 0) chk("rt_rx_data", rx_q[0], 8'hF8);
        chk("rt_act_in", ain_n, 0);
        chk("rt_act_out", aout_n, 0);
        cmp_tx("rt_tx");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
